pcie_perst_gen: RTL and testbench



---
 rtl/pcie_perst_gen.sv | 170 +++++++++++++++++
 tb/tb_pcie_perst_gen.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pcie_perst_gen.sv
// pcie_perst_gen
//   Host-side PERST# sequencer for a PCIe endpoint. PERST# stays asserted
//   until power-good and the reference-clock lock are both seen. It is then
//   held for T_PVPERL_CYC more cycles and released. Link training is
//   supervised with a timeout. Retries pass through a minimum-width warm
//   reset, and the block parks in FAIL after MAX_RETRY retries have also
//   timed out. Software can request a warm reset from TRAIN, UP or FAIL.
//
// Ports
//   clk_clk          in   free-running system clock
//   reset_reset      in   synchronous active-high reset
//   power_good_in    in   async, 2-flop synchronized
//   refclk_locked_in in   async, 2-flop synchronized
//   link_up_in       in   async endpoint link status, 2-flop synchronized
//   sw_reset_req     in   single-cycle warm-reset request (clk_clk domain)
//   perst_n_out      out  PERST# to the endpoint, low = reset asserted
//   state_out        out  current state (HOLD=0 PVPERL=1 TRAIN=2 UP=3 WRST=4 FAIL=5)
//   retry_cnt        out  training retries since last link-up or clear
//   link_up_cnt      out  link-up events, saturating at 0xFFFF
//   fail             out  high while in FAIL
module pcie_perst_gen #(
    parameter int unsigned T_PVPERL_CYC    = 10_000_000,
    parameter int unsigned T_PERST_MIN_CYC = 10_000,
    parameter int unsigned T_LINK_TO_CYC   = 20_000_000,
    parameter int unsigned MAX_RETRY       = 3,
    parameter int unsigned CNT_W           = 25
) (
    input  logic        clk_clk,
    input  logic        reset_reset,
    input  logic        power_good_in,
    input  logic        refclk_locked_in,
    input  logic        link_up_in,
    input  logic        sw_reset_req,
    output logic        perst_n_out,
    output logic [2:0]  state_out,
    output logic [3:0]  retry_cnt,
    output logic [15:0] link_up_cnt,
    output logic        fail
);

    typedef enum logic [2:0] {
        ST_HOLD   = 3'd0,
        ST_PVPERL = 3'd1,
        ST_TRAIN  = 3'd2,
        ST_UP     = 3'd3,
        ST_WRST   = 3'd4,
        ST_FAIL   = 3'd5
    } state_t;

    // The timer starts at 0 on state entry, so the last cycle of a T-cycle
    // window is T-1.
    localparam logic [CNT_W-1:0] PVPERL_LAST = CNT_W'(T_PVPERL_CYC - 1);
    localparam logic [CNT_W-1:0] PMIN_LAST   = CNT_W'(T_PERST_MIN_CYC - 1);
    localparam logic [CNT_W-1:0] LINKTO_LAST = CNT_W'(T_LINK_TO_CYC - 1);
    localparam logic [3:0]       RETRY_MAX   = 4'(MAX_RETRY);

    // Synchronizer bit order: {link, lock, pg}.
    logic [2:0]       meta_d,  meta_q;
    logic [2:0]       sync_d,  sync_q;
    state_t           state_d, state_q;
    logic [CNT_W-1:0] timer_d, timer_q;
    logic [3:0]       retry_d, retry_q;
    logic [15:0]      luc_d,   luc_q;
    logic             perst_n_d, perst_n_q;
    logic             fail_d,  fail_q;

    logic pg_s, lock_s, link_s, pwr_ok, timed;

    assign pg_s   = sync_q[0];
    assign lock_s = sync_q[1];
    assign link_s = sync_q[2];
    assign pwr_ok = pg_s && lock_s;

    always_comb begin
        meta_d    = {link_up_in, refclk_locked_in, power_good_in};
        sync_d    = meta_q;
        state_d   = state_q;
        retry_d   = retry_q;
        luc_d     = luc_q;
        timer_d   = timer_q;
        timed     = 1'b0;

        // Losing power or refclk overrides everything except reset.
        if ((state_q != ST_HOLD) && !pwr_ok) begin
            state_d = ST_HOLD;
            retry_d = '0;
        end else begin
            unique case (state_q)
                ST_HOLD: begin
                    if (pwr_ok) state_d = ST_PVPERL;
                end
                ST_PVPERL: begin
                    timed = 1'b1;
                    if (timer_q == PVPERL_LAST) state_d = ST_TRAIN;
                end
                ST_TRAIN: begin
                    timed = 1'b1;
                    // A software request beats a coincident link-up or
                    // timeout. A warm reset it causes does not count as a retry.
                    if (sw_reset_req) begin
                        state_d = ST_WRST;
                    end else if (link_s) begin
                        state_d = ST_UP;
                        retry_d = '0;
                        if (luc_q != 16'hFFFF) luc_d = luc_q + 16'd1;
                    end else if (timer_q == LINKTO_LAST) begin
                        if (retry_q < RETRY_MAX) begin
                            retry_d = retry_q + 4'd1;
                            state_d = ST_WRST;
                        end else begin
                            state_d = ST_FAIL;
                        end
                    end
                end
                ST_UP: begin
                    if (sw_reset_req)  state_d = ST_WRST;
                    else if (!link_s)  state_d = ST_TRAIN;
                end
                ST_WRST: begin
                    timed = 1'b1;
                    if (timer_q == PMIN_LAST) state_d = ST_TRAIN;
                end
                ST_FAIL: begin
                    if (sw_reset_req) begin
                        retry_d = '0;
                        state_d = ST_WRST;
                    end
                end
                default: state_d = ST_HOLD;
            endcase
        end

        if (state_d != state_q) timer_d = '0;
        else if (timed)         timer_d = timer_q + 1'b1;

        // Registered from the next-state decode, so PERST# moves on the same
        // edge as state_out.
        perst_n_d = (state_d == ST_TRAIN) || (state_d == ST_UP);
        fail_d    = (state_d == ST_FAIL);
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            meta_q    <= '0;
            sync_q    <= '0;
            state_q   <= ST_HOLD;
            timer_q   <= '0;
            retry_q   <= '0;
            luc_q     <= '0;
            perst_n_q <= 1'b0;
            fail_q    <= 1'b0;
        end else begin
            meta_q    <= meta_d;
            sync_q    <= sync_d;
            state_q   <= state_d;
            timer_q   <= timer_d;
            retry_q   <= retry_d;
            luc_q     <= luc_d;
            perst_n_q <= perst_n_d;
            fail_q    <= fail_d;
        end
    end

    assign perst_n_out = perst_n_q;
    assign state_out   = state_q;
    assign retry_cnt   = retry_q;
    assign link_up_cnt = luc_q;
    assign fail        = fail_q;

endmodule

// File: tb/tb_pcie_perst_gen.sv
// Bench for pcie_perst_gen: directed scenarios plus randomized traffic, all
// compared against a deadline-based reference model of the sequencer.
module tb_pcie_perst_gen;

    localparam int TPV  = 20;
    localparam int TMIN = 5;
    localparam int TTO  = 30;
    localparam int MAXR = 2;

    localparam int S_HOLD = 0, S_PV = 1, S_TR = 2, S_UP = 3, S_WR = 4, S_FAIL = 5;

    logic clk = 1'b0;
    logic rst = 1'b1, pg = 1'b0, lock = 1'b0, link = 1'b0, sw = 1'b0;
    logic        perst_n_out;
    logic [2:0]  state_out;
    logic [3:0]  retry_cnt;
    logic [15:0] link_up_cnt;
    logic        fail;
    logic [24:0] got;

    pcie_perst_gen #(
        .T_PVPERL_CYC    (TPV),
        .T_PERST_MIN_CYC (TMIN),
        .T_LINK_TO_CYC   (TTO),
        .MAX_RETRY       (MAXR),
        .CNT_W           (25)
    ) dut (
        .clk_clk          (clk),
        .reset_reset      (rst),
        .power_good_in    (pg),
        .refclk_locked_in (lock),
        .link_up_in       (link),
        .sw_reset_req     (sw),
        .perst_n_out      (perst_n_out),
        .state_out        (state_out),
        .retry_cnt        (retry_cnt),
        .link_up_cnt      (link_up_cnt),
        .fail             (fail)
    );

    always #5 clk = ~clk;

    assign got = {perst_n_out, state_out, retry_cnt, link_up_cnt, fail};

    int n_vec = 0;
    int n_err = 0;

    // Reference model: each timed phase records the edge it was entered on and
    // leaves exactly T edges later. Async inputs reach the decision logic
    // through a 2-deep history.
    int       cyc = 0;
    int       m_state = S_HOLD;
    int       m_enter = 0;
    int       m_retry = 0;
    int       m_luc = 0;
    bit [1:0] h_pg = '0, h_lk = '0, h_ln = '0;

    function automatic logic [24:0] exp_vec();
        logic p;
        p = (m_state == S_TR) || (m_state == S_UP);
        return {p, 3'(m_state), 4'(m_retry), 16'(m_luc), (m_state == S_FAIL)};
    endfunction

    task automatic tick();
        bit pgs, lks, lns;
        int nxt;
        @(posedge clk);
        cyc++;
        if (rst) begin
            m_state = S_HOLD; m_enter = cyc; m_retry = 0; m_luc = 0;
            h_pg = '0; h_lk = '0; h_ln = '0;
        end else begin
            pgs = h_pg[1]; lks = h_lk[1]; lns = h_ln[1];
            h_pg = {h_pg[0], pg}; h_lk = {h_lk[0], lock}; h_ln = {h_ln[0], link};
            nxt = m_state;
            if (m_state != S_HOLD && !(pgs && lks)) begin
                nxt = S_HOLD; m_retry = 0;
            end else begin
                case (m_state)
                    S_HOLD: if (pgs && lks) nxt = S_PV;
                    S_PV:   if (cyc - m_enter == TPV) nxt = S_TR;
                    S_TR: begin
                        if (sw) nxt = S_WR;
                        else if (lns) begin
                            nxt = S_UP; m_retry = 0;
                            if (m_luc < 65535) m_luc++;
                        end else if (cyc - m_enter == TTO) begin
                            if (m_retry < MAXR) begin m_retry++; nxt = S_WR; end
                            else nxt = S_FAIL;
                        end
                    end
                    S_UP:   if (sw) nxt = S_WR; else if (!lns) nxt = S_TR;
                    S_WR:   if (cyc - m_enter == TMIN) nxt = S_TR;
                    S_FAIL: if (sw) begin m_retry = 0; nxt = S_WR; end
                    default: nxt = S_HOLD;
                endcase
            end
            if (nxt != m_state) m_enter = cyc;
            m_state = nxt;
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; pg = 1'b0; lock = 1'b0; link = 1'b0; sw = 1'b0;
        tick(); tick();
        n_vec++; if (got !== 25'd0) begin n_err++; $display("FAIL reset_values got=%h want=%h", got, 25'd0); end
        n_vec++; if (got !== exp_vec()) begin n_err++; $display("FAIL model_reset got=%h want=%h", got, exp_vec()); end
    endtask

    task automatic test_power_up();
        pg = 1'b1; lock = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            tick();
            n_vec++; if (got !== exp_vec()) begin n_err++; $display("FAIL model_pwrup got=%h want=%h", got, exp_vec()); end
            n_vec++; if (state_out !== ((i == 3) ? 3'd1 : 3'd0)) begin n_err++; $display("FAIL pwrup_state edge=%0d got=%0d want=%0d", i, state_out, (i == 3) ? 1 : 0); end
        end
        for (int i = 1; i <= TPV; i++) begin
            tick();
            n_vec++; if (got !== exp_vec()) begin n_err++; $display("FAIL model_pvperl got=%h want=%h", got, exp_vec()); end
            n_vec++; if ({perst_n_out, state_out} !== ((i == TPV) ? 4'b1_010 : 4'b0_001)) begin
                n_err++; $display("FAIL pvperl_release i=%0d got perst=%b state=%0d", i, perst_n_out, state_out);
            end
        end
    endtask

    task automatic test_link_up();
        for (int i = 1; i <= 10; i++) begin
            tick();
            n_vec++; if (got !== exp_vec()) begin n_err++; $display("FAIL model_train got=%h want=%h", got, exp_vec()); end
        end
        link = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            n_vec++; if (state_out !== ((i == 3) ? 3'd3 : 3'd2)) begin n_err++; $display("FAIL linkup_state edge=%0d got=%0d want=%0d", i, state_out, (i == 3) ? 3 : 2); end
        end
        n_vec++; if ({link_up_cnt, retry_cnt} !== {16'd1, 4'd0}) begin n_err++; $display("FAIL linkup_counts got luc=%0d retry=%0d want 1/0", link_up_cnt, retry_cnt); end
        n_vec++; if (got !== exp_vec()) begin n_err++; $display("FAIL model_up got=%h want=%h", got, exp_vec()); end
    endtask

    task automatic test_warm_reset();
        sw = 1'b1;
        tick();
        sw = 1'b0;
        n_vec++; if ({perst_n_out, state_out} !== 4'b0_100) begin n_err++; $display("FAIL warm_enter got perst=%b state=%0d want 0/4", perst_n_out, state_out); end
        for (int i = 1; i <= TMIN; i++) begin
            tick();
            n_vec++; if ({perst_n_out, state_out} !== ((i == TMIN) ? 4'b1_010 : 4'b0_100)) begin
                n_err++; $display("FAIL warm_width i=%0d got perst=%b state=%0d", i, perst_n_out, state_out);
            end
        end
        tick();
        n_vec++; if ({state_out, link_up_cnt} !== {3'd3, 16'd2}) begin n_err++; $display("FAIL warm_relink got state=%0d luc=%0d want 3/2", state_out, link_up_cnt); end
        n_vec++; if (got !== exp_vec()) begin n_err++; $display("FAIL model_warm got=%h want=%h", got, exp_vec()); end
    endtask

    task automatic test_timeout();
        link = 1'b0;
        for (int i = 1; i <= 3; i++) tick();
        n_vec++; if (state_out !== 3'd2) begin n_err++; $display("FAIL linkdown_state got=%0d want=2", state_out); end
        for (int r = 1; r <= MAXR + 1; r++) begin
            for (int i = 1; i <= TTO; i++) begin
                tick();
                n_vec++; if (got !== exp_vec()) begin n_err++; $display("FAIL model_timeout got=%h want=%h", got, exp_vec()); end
            end
            if (r <= MAXR) begin
                n_vec++; if ({perst_n_out, state_out, retry_cnt} !== {1'b0, 3'd4, 4'(r)}) begin
                    n_err++; $display("FAIL timeout_retry r=%0d got perst=%b state=%0d retry=%0d", r, perst_n_out, state_out, retry_cnt);
                end
                for (int i = 1; i <= TMIN; i++) tick();
                n_vec++; if ({perst_n_out, state_out} !== 4'b1_010) begin n_err++; $display("FAIL retry_release r=%0d got perst=%b state=%0d", r, perst_n_out, state_out); end
            end
        end
        for (int i = 1; i <= 10; i++) begin
            tick();
            n_vec++; if ({perst_n_out, state_out, fail, retry_cnt} !== {1'b0, 3'd5, 1'b1, 4'd2}) begin
                n_err++; $display("FAIL fail_hold i=%0d got perst=%b state=%0d fail=%b retry=%0d", i, perst_n_out, state_out, fail, retry_cnt);
            end
        end
        sw = 1'b1;
        tick();
        sw = 1'b0;
        n_vec++; if ({state_out, retry_cnt, fail} !== {3'd4, 4'd0, 1'b0}) begin n_err++; $display("FAIL fail_clear got state=%0d retry=%0d fail=%b", state_out, retry_cnt, fail); end
        for (int i = 1; i <= TMIN; i++) tick();
        n_vec++; if (got !== exp_vec()) begin n_err++; $display("FAIL model_clear got=%h want=%h", got, exp_vec()); end
    endtask

    task automatic test_power_loss();
        for (int i = 1; i <= TTO + TMIN + 4; i++) tick();
        n_vec++; if ({state_out, retry_cnt} !== {3'd2, 4'd1}) begin n_err++; $display("FAIL ploss_pre got state=%0d retry=%0d want 2/1", state_out, retry_cnt); end
        pg = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            tick();
            n_vec++; if ({perst_n_out, state_out} !== ((i == 3) ? 4'b0_000 : 4'b1_010)) begin
                n_err++; $display("FAIL ploss_edge i=%0d got perst=%b state=%0d", i, perst_n_out, state_out);
            end
        end
        n_vec++; if (retry_cnt !== 4'd0) begin n_err++; $display("FAIL ploss_retry got=%0d want=0", retry_cnt); end
        for (int i = 1; i <= 4; i++) tick();
        pg = 1'b1;
        for (int i = 1; i <= 3; i++) tick();
        n_vec++; if (state_out !== 3'd1) begin n_err++; $display("FAIL prestore_pv got=%0d want=1", state_out); end
        for (int i = 1; i <= TPV; i++) begin
            tick();
            n_vec++; if (state_out !== ((i == TPV) ? 3'd2 : 3'd1)) begin n_err++; $display("FAIL prestore_len i=%0d got=%0d", i, state_out); end
        end
    endtask

    task automatic test_mid_reset();
        rst = 1'b1; tick(); rst = 1'b0;
        for (int i = 1; i <= 3 + 10; i++) tick();
        n_vec++; if (state_out !== 3'd1) begin n_err++; $display("FAIL midrst_pre got=%0d want=1", state_out); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_vec++; if (got !== 25'd0) begin n_err++; $display("FAIL midrst_values got=%h want=%h", got, 25'd0); end
        for (int i = 1; i <= 3; i++) tick();
        n_vec++; if (state_out !== 3'd1) begin n_err++; $display("FAIL midrst_pv got=%0d want=1", state_out); end
        for (int i = 1; i <= TPV; i++) begin
            tick();
            n_vec++; if ({perst_n_out, state_out} !== ((i == TPV) ? 4'b1_010 : 4'b0_001)) begin
                n_err++; $display("FAIL midrst_len i=%0d got perst=%b state=%0d", i, perst_n_out, state_out);
            end
        end
    endtask

    task automatic test_random();
        rst = 1'b1; tick(); rst = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if (pg)   pg   = ($urandom_range(0, 299) != 0); else pg   = ($urandom_range(0, 7) == 0);
            if (lock) lock = ($urandom_range(0, 399) != 0); else lock = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 39) == 0) link = ~link;
            sw  = ($urandom_range(0, 59) == 0);
            rst = ($urandom_range(0, 799) == 0);
            tick();
            n_vec++; if (got !== exp_vec()) begin n_err++; $display("FAIL model_random i=%0d got=%h want=%h", i, got, exp_vec()); end
        end
        rst = 1'b0; sw = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_power_up();
        test_link_up();
        test_warm_reset();
        test_timeout();
        test_power_loss();
        test_mid_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
